reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register and port data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width (2**ADDR_W registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port src1_addr, input, ADDR_W, read port 1 register select.
REQ-006 The block SHALL have port src2_addr, input, ADDR_W, read port 2 register select.
REQ-007 The block SHALL have port src1_data, output, DATA_W, read port 1 data (A operand to the shifter/ALU).
REQ-008 The block SHALL have port src2_data, output, DATA_W, read port 2 data (B operand; bits [4:0] serve as shift amount).
REQ-009 The block SHALL have port wr_en, input, 1, write-back enable.
REQ-010 The block SHALL have port dst_addr, input, ADDR_W, write-back register select.
REQ-011 The block SHALL have port wr_data, input, DATA_W, write-back data (shifter/ALU result).
REQ-012 The block SHALL have port err_r0_wr, output, 1, registered flag set for one cycle after an attempted write to R0.

Function
REQ-013 The block SHALL hold 2**ADDR_W registers R0..R(N-1), each DATA_W bits.
REQ-014 R0 SHALL read as all zeros at all times; writes to R0 SHALL be discarded.
REQ-015 On a rising clk edge with rst_n high, wr_en high and dst_addr != 0, R[dst_addr] SHALL take wr_data.
REQ-016 With wr_en low, no register SHALL change.
REQ-017 Reads SHALL be combinational: srcX_data reflects R[srcX_addr] in the same cycle the address is applied (zero-cycle latency).
REQ-018 Write-through bypass: when rst_n high, wr_en high, dst_addr == srcX_addr and dst_addr != 0, srcX_data SHALL equal wr_data in that same cycle.
REQ-019 The bypass SHALL apply independently to each read port; both ports addressing the same register SHALL both receive identical data (bypassed or stored).
REQ-020 Bypass SHALL be suppressed when dst_addr == 0 (srcX_data stays 0 for address 0).
REQ-021 err_r0_wr SHALL be 1 in the cycle after a rising edge at which rst_n high, wr_en high and dst_addr == 0; otherwise 0.
REQ-022 Addresses SHALL be used unmodified; no wrap or truncation beyond ADDR_W bits.
REQ-023 Read outputs SHALL never be X after reset for any address value.

Reset
REQ-024 On a rising clk edge with rst_n low, all registers SHALL clear to 0 and err_r0_wr SHALL clear to 0.
REQ-025 While rst_n is low, writes SHALL be ignored and bypass suppressed; srcX_data SHALL reflect stored contents (0 after the first reset edge).
REQ-026 Reset asserted mid-operation SHALL take priority over a concurrent write on the same edge; the written register ends at 0.
REQ-027 Before the first reset edge, register contents are unspecified; the bench SHALL not check reads in that interval.

Verification
REQ-028 Reset then read all 16 addresses on both ports -> every srcX_data = 16'h0000, err_r0_wr = 0.
REQ-029 Write R5 = 16'hA5A5 (wr_en=1, dst_addr=5), next cycle src1_addr=5, src2_addr=5 -> both outputs 16'hA5A5.
REQ-030 Same-cycle bypass: R3 holds 16'h1111; wr_en=1, dst_addr=3, wr_data=16'h00FF, src2_addr=3 -> src2_data=16'h00FF same cycle, 16'h00FF stored next cycle.
REQ-031 Write to R0: wr_en=1, dst_addr=0, wr_data=16'hFFFF, src1_addr=0 -> src1_data=16'h0000 same and next cycle; err_r0_wr=1 for exactly one cycle.
REQ-032 Reset during write: rst_n=0 with wr_en=1, dst_addr=7, wr_data=16'h1234 on same edge -> R7 reads 16'h0000 afterwards.
REQ-033 Operand feed to shifter: R1=16'h0001, R2=16'h0004, src1_addr=1, src2_addr=2 -> src1_data=16'h0001, src2_data[4:0]=5'd4; write-back of 16'h0010 to R6 reads back 16'h0010.

Source files
------------

// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port.
// R0 reads as zero. Each read port forwards a same-cycle write.
module reg_rd_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            dst_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            data
);
  logic zero_sel;
  logic bypass;

  assign zero_sel = (addr == '0);
  // R0 is never forwarded, and nothing is forwarded while reset is held.
  assign bypass   = rst_n && wr_en && (dst_addr == addr) && !zero_sel;

  always_comb begin
    data = regs[addr];
    if (zero_sel)    data = '0;
    else if (bypass) data = wr_data;
  end
endmodule

module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  output logic [DATA_W-1:0] src1_data,
  output logic [DATA_W-1:0] src2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              err_r0_wr
);
  localparam int NREGS    = 1 << ADDR_W;
  localparam int NUM_PORTS = 2;

  logic [NREGS-1:0][DATA_W-1:0]     regs;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;

  // Reset wins over a concurrent write. R0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs      <= '0;
      err_r0_wr <= 1'b0;
    end else begin
      if (wr_en && (dst_addr != '0)) regs[dst_addr] <= wr_data;
      err_r0_wr <= wr_en && (dst_addr == '0);
    end
  end

  assign rd_addr[0] = src1_addr;
  assign rd_addr[1] = src2_addr;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
      reg_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd (
        .regs     (regs),
        .addr     (rd_addr[p]),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .dst_addr (dst_addr),
        .wr_data  (wr_data),
        .data     (rd_data[p])
      );
    end
  endgenerate

  assign src1_data = rd_data[0];
  assign src2_data = rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Directed and random stimulus for reg_file, checked against an array model.
module tb_reg_file;
  logic        clk;
  logic        rst_n;
  logic [3:0]  src1_addr, src2_addr, dst_addr;
  logic [15:0] src1_data, src2_data, wr_data;
  logic        wr_en;
  logic        err_r0_wr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];
  logic        exp_err;
  bit          seen_reset = 0;

  reg_file #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src1_addr (src1_addr),
    .src2_addr (src2_addr),
    .src1_data (src1_data),
    .src2_data (src2_data),
    .wr_en     (wr_en),
    .dst_addr  (dst_addr),
    .wr_data   (wr_data),
    .err_r0_wr (err_r0_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the rules: R0 is zero, a live write forwards, else stored.
  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (rst_n && wr_en && dst_addr == a) return wr_data;
    return mem[a];
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, then advance the model.
  task automatic cyc(input logic r, input logic we, input logic [3:0] d,
                     input logic [15:0] wd, input logic [3:0] a1, input logic [3:0] a2);
    rst_n = r; wr_en = we; dst_addr = d; wr_data = wd;
    src1_addr = a1; src2_addr = a2;
    #2;
    if (seen_reset) begin
      chk("src1", src1_data, exp_rd(a1));
      chk("src2", src2_data, exp_rd(a2));
      chk("err_r0_wr", {15'd0, err_r0_wr}, {15'd0, exp_err});
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      exp_err = 1'b0;
      seen_reset = 1;
    end else begin
      if (we && d != 4'd0) mem[d] = wd;
      exp_err = we && (d == 4'd0);
    end
    #1;
  endtask

  initial begin
    exp_err = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 'x;

    cyc(0, 0, 0, 16'h0, 0, 0);
    for (int a = 0; a < 16; a++) cyc(1, 0, 0, 16'h0, a[3:0], 4'(15 - a));

    cyc(1, 1, 5, 16'hA5A5, 0, 0);
    cyc(1, 0, 0, 16'h0, 5, 5);
    chk("r5_direct", src1_data, 16'hA5A5);

    cyc(1, 1, 3, 16'h1111, 0, 0);
    cyc(1, 1, 3, 16'h00FF, 0, 3);
    cyc(1, 0, 0, 16'h0, 3, 3);
    chk("r3_stored", src2_data, 16'h00FF);

    cyc(1, 1, 0, 16'hFFFF, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    chk("err_one_cycle", {15'd0, err_r0_wr}, 16'h0000);

    cyc(1, 1, 7, 16'h5555, 0, 0);
    cyc(0, 1, 7, 16'h1234, 7, 7);
    cyc(1, 0, 0, 16'h0, 7, 7);
    chk("r7_after_reset", src1_data, 16'h0000);

    cyc(1, 1, 1, 16'h0001, 0, 0);
    cyc(1, 1, 2, 16'h0004, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 2);
    chk("shamt", {11'd0, src2_data[4:0]}, 16'd4);
    cyc(1, 1, 6, 16'h0010, 1, 2);
    cyc(1, 0, 0, 16'h0, 6, 6);
    chk("r6_wb", src1_data, 16'h0010);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] d, a1, a2;
      d  = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), d,
          16'($urandom), a1, a2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
